// File: rtl/normalizer_and_packer.sv
`default_nettype none
// ============================================================================
//  Module      : normalizer_and_packer
//  Description : Back-end of the single-precision FP adder. Takes the raw
//                sign/exponent/mantissa/carry from the add stage, normalises
//                the mantissa one bit per cycle, range-checks the exponent
//                and packs the IEEE-754 word with Overflow/Underflow/Zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module normalizer_and_packer #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic                   S_In,
    input  logic [EXP_W-1:0]       E_In,
    input  logic [MAN_W-1:0]       M_In,
    input  logic                   Carry_In,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [EXP_W+MAN_W-1:0] Result,
    output logic                   Overflow,
    output logic                   Underflow,
    output logic                   Zero
);

    localparam logic [EXP_W-1:0]       C_EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]       C_EXP_ONE  = EXP_W'(1);
    localparam logic [EXP_W+MAN_W-1:0] C_RES_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q,     state_d;
    logic                     s_q,         s_d;
    logic [EXP_W-1:0]         e_q,         e_d;
    logic [MAN_W-1:0]         m_q,         m_d;
    logic [EXP_W+MAN_W-1:0]   result_q,    result_d;
    logic                     ovf_q,       ovf_d;
    logic                     unf_q,       unf_d;
    logic                     zero_q,      zero_d;
    logic                     out_valid_q, out_valid_d;

    logic [EXP_W-1:0]         w_e_inc;
    logic [EXP_W-1:0]         w_e_dec;
    logic [MAN_W-1:0]         w_m_shift;

    assign w_e_inc   = E_In + C_EXP_ONE;
    assign w_e_dec   = e_q - C_EXP_ONE;
    assign w_m_shift = {m_q[MAN_W-2:0], 1'b0};

    // Next-state, datapath and registered-output computation for the FSM.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        e_d         = e_q;
        m_d         = m_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (In_Valid) begin
                    s_d    = S_In;
                    e_d    = E_In;
                    m_d    = M_In;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    zero_d = 1'b0;
                    if (E_In == C_EXP_ONES) begin
                        // Input already at Inf exponent: saturate.
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        ovf_d       = 1'b1;
                        result_d    = {S_In, C_EXP_ONES, {(MAN_W-1){1'b0}}};
                    end else if (Carry_In) begin
                        // Carry-out: one right shift brings the carry into the hidden bit.
                        m_d         = {1'b1, M_In[MAN_W-1:1]};
                        e_d         = w_e_inc;
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        if (w_e_inc == C_EXP_ONES) begin
                            ovf_d    = 1'b1;
                            result_d = {S_In, C_EXP_ONES, {(MAN_W-1){1'b0}}};
                        end else begin
                            result_d = {S_In, w_e_inc, M_In[MAN_W-1:1]};
                        end
                    end else if (M_In == '0) begin
                        // Exact cancellation always yields +0.
                        s_d         = 1'b0;
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        zero_d      = 1'b1;
                        result_d    = C_RES_ZERO;
                    end else if (M_In[MAN_W-1]) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        if (E_In == '0) begin
                            // Exponent 0 would be a denormal encoding: flush.
                            unf_d    = 1'b1;
                            zero_d   = 1'b1;
                            result_d = C_RES_ZERO;
                        end else begin
                            result_d = {S_In, E_In, M_In[MAN_W-2:0]};
                        end
                    end else begin
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                if (e_q <= C_EXP_ONE) begin
                    // No exponent headroom left for another shift: flush to +0.
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    unf_d       = 1'b1;
                    zero_d      = 1'b1;
                    result_d    = C_RES_ZERO;
                end else begin
                    m_d = w_m_shift;
                    e_d = w_e_dec;
                    if (w_m_shift[MAN_W-1]) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = {s_q, w_e_dec, w_m_shift[MAN_W-2:0]};
                    end
                end
            end

            DONE: begin
                if (Out_Ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any pending operation.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            s_q         <= 1'b0;
            e_q         <= '0;
            m_q         <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            e_q         <= e_d;
            m_q         <= m_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign In_Ready  = (state_q == IDLE);
    assign Out_Valid = out_valid_q;
    assign Result    = result_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_normalizer_and_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_normalizer_and_packer
//  Description : Directed self-checking bench for normalizer_and_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_normalizer_and_packer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        In_Valid;
    logic        In_Ready;
    logic        S_In;
    logic [7:0]  E_In;
    logic [23:0] M_In;
    logic        Carry_In;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Result;
    logic        Overflow;
    logic        Underflow;
    logic        Zero;

    int tests_run = 0;
    int tests_failed = 0;

    normalizer_and_packer #(.EXP_W(8), .MAN_W(24)) dut (
        .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .S_In(S_In), .E_In(E_In), .M_In(M_In), .Carry_In(Carry_In),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Result(Result),
        .Overflow(Overflow), .Underflow(Underflow), .Zero(Zero)
    );

    always #5 Clk = ~Clk;

    // Present one operand for one edge, then count edges until Out_Valid.
    task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m,
                        input logic c, output int lat);
        S_In = s; E_In = e; M_In = m; Carry_In = c; In_Valid = 1'b1;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        lat = 1;
        while (Out_Valid !== 1'b1 && lat < 64) begin
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic consume;
        Out_Ready = 1'b1;
        @(posedge Clk); #1;
        Out_Ready = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0;
        S_In = 1'b0; E_In = '0; M_In = '0; Carry_In = 1'b0;
        repeat (2) @(posedge Clk); #1;
        tests_run++;
        if ({Out_Valid, In_Ready, Overflow, Underflow, Zero} !== 5'b01000 || Result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset: ov/ir/flags=%b result=%h, expected 01000 / 00000000",
                     {Out_Valid, In_Ready, Overflow, Underflow, Zero}, Result);
        end
        Reset = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_carry;
        int lat;
        send(1'b0, 8'h7F, 24'h000000, 1'b1, lat);
        tests_run++;
        if (lat !== 1 || Result !== 32'h40000000 || {Overflow, Underflow, Zero} !== 3'b000) begin
            tests_failed++;
            $display("FAIL carry_t1: lat=%0d result=%h flags=%b, expected 1 40000000 000",
                     lat, Result, {Overflow, Underflow, Zero});
        end
        tests_run++;
        if (In_Ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL in_ready_done: got %b expected 0", In_Ready);
        end
        consume();
        tests_run++;
        if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_consume: ov=%b ir=%b expected 0 1", Out_Valid, In_Ready);
        end
        send(1'b1, 8'h10, 24'hABCDEF, 1'b1, lat);
        tests_run++;
        if (lat !== 1 || Result !== 32'h88D5E6F7 || {Overflow, Underflow, Zero} !== 3'b000) begin
            tests_failed++;
            $display("FAIL carry_frac: lat=%0d result=%h flags=%b, expected 1 88D5E6F7 000",
                     lat, Result, {Overflow, Underflow, Zero});
        end
        consume();
    endtask

    task automatic test_normalised;
        int lat;
        send(1'b1, 8'h7F, 24'hC00000, 1'b0, lat);
        tests_run++;
        if (lat !== 1 || Result !== 32'hBFC00000 || {Overflow, Underflow, Zero} !== 3'b000) begin
            tests_failed++;
            $display("FAIL normalised_t2: lat=%0d result=%h flags=%b, expected 1 BFC00000 000",
                     lat, Result, {Overflow, Underflow, Zero});
        end
        consume();
        send(1'b0, 8'h80, 24'h400001, 1'b0, lat);
        tests_run++;
        if (lat !== 2 || Result !== 32'h3F800002 || {Overflow, Underflow, Zero} !== 3'b000) begin
            tests_failed++;
            $display("FAIL one_shift: lat=%0d result=%h flags=%b, expected 2 3F800002 000",
                     lat, Result, {Overflow, Underflow, Zero});
        end
        consume();
    endtask

    task automatic test_cancellation;
        int lat;
        send(1'b0, 8'h85, 24'h000001, 1'b0, lat);
        tests_run++;
        if (lat !== 24 || Result !== 32'h37000000 || {Overflow, Underflow, Zero} !== 3'b000) begin
            tests_failed++;
            $display("FAIL cancel_t3: lat=%0d result=%h flags=%b, expected 24 37000000 000",
                     lat, Result, {Overflow, Underflow, Zero});
        end
        consume();
    endtask

    task automatic test_zero_overflow;
        int lat;
        send(1'b1, 8'h40, 24'h000000, 1'b0, lat);
        tests_run++;
        if (lat !== 1 || Result !== 32'h00000000 || {Overflow, Underflow, Zero} !== 3'b001) begin
            tests_failed++;
            $display("FAIL zero_t4: lat=%0d result=%h flags=%b, expected 1 00000000 001",
                     lat, Result, {Overflow, Underflow, Zero});
        end
        consume();
        send(1'b0, 8'hFE, 24'h800000, 1'b1, lat);
        tests_run++;
        if (lat !== 1 || Result !== 32'h7F800000 || {Overflow, Underflow, Zero} !== 3'b100) begin
            tests_failed++;
            $display("FAIL carry_ovf_t4: lat=%0d result=%h flags=%b, expected 1 7F800000 100",
                     lat, Result, {Overflow, Underflow, Zero});
        end
        consume();
        send(1'b1, 8'hFF, 24'h123456, 1'b0, lat);
        tests_run++;
        if (lat !== 1 || Result !== 32'hFF800000 || {Overflow, Underflow, Zero} !== 3'b100) begin
            tests_failed++;
            $display("FAIL inf_exp: lat=%0d result=%h flags=%b, expected 1 FF800000 100",
                     lat, Result, {Overflow, Underflow, Zero});
        end
        consume();
    endtask

    task automatic test_underflow;
        int lat;
        send(1'b0, 8'h03, 24'h000100, 1'b0, lat);
        tests_run++;
        if (lat !== 4 || Result !== 32'h00000000 || {Overflow, Underflow, Zero} !== 3'b011) begin
            tests_failed++;
            $display("FAIL underflow_t5: lat=%0d result=%h flags=%b, expected 4 00000000 011",
                     lat, Result, {Overflow, Underflow, Zero});
        end
        consume();
        send(1'b1, 8'h00, 24'h800000, 1'b0, lat);
        tests_run++;
        if (lat !== 1 || Result !== 32'h00000000 || {Overflow, Underflow, Zero} !== 3'b011) begin
            tests_failed++;
            $display("FAIL exp0_flush: lat=%0d result=%h flags=%b, expected 1 00000000 011",
                     lat, Result, {Overflow, Underflow, Zero});
        end
        consume();
    endtask

    task automatic test_handshake;
        int lat;
        send(1'b1, 8'h7F, 24'hC00000, 1'b0, lat);
        // Offer a different operand while stalled; it must be ignored.
        S_In = 1'b0; E_In = 8'h20; M_In = 24'h800000; Carry_In = 1'b0; In_Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            tests_run++;
            if (Out_Valid !== 1'b1 || In_Ready !== 1'b0 || Result !== 32'hBFC00000) begin
                tests_failed++;
                $display("FAIL stall_cycle%0d: ov=%b ir=%b result=%h, expected 1 0 BFC00000",
                         i, Out_Valid, In_Ready, Result);
            end
        end
        In_Valid = 1'b0;
        consume();
        tests_run++;
        if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release: ov=%b ir=%b expected 0 1", Out_Valid, In_Ready);
        end
    endtask

    task automatic test_reset_mid_norm;
        int lat;
        S_In = 1'b0; E_In = 8'h85; M_In = 24'h000001; Carry_In = 1'b0; In_Valid = 1'b1;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        tests_run++;
        if (In_Ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL norm_busy: ir=%b expected 0", In_Ready);
        end
        Reset = 1'b1;
        #1;
        tests_run++;
        if (Out_Valid !== 1'b0 || In_Ready !== 1'b1 || Result !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: ov=%b ir=%b result=%h expected 0 1 00000000",
                     Out_Valid, In_Ready, Result);
        end
        #2;
        Reset = 1'b0;
        @(posedge Clk); #1;
        send(1'b1, 8'h7F, 24'hC00000, 1'b0, lat);
        tests_run++;
        if (lat !== 1 || Result !== 32'hBFC00000 || {Overflow, Underflow, Zero} !== 3'b000) begin
            tests_failed++;
            $display("FAIL post_reset_op: lat=%0d result=%h flags=%b, expected 1 BFC00000 000",
                     lat, Result, {Overflow, Underflow, Zero});
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_carry();
        test_normalised();
        test_cancellation();
        test_zero_overflow();
        test_underflow();
        test_handshake();
        test_reset_mid_norm();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
